// File: rtl/axis_pkt_pkg.sv
// Shared constants and helpers for the LPC AXI-Stream frame packetizer.
package axis_pkt_pkg;

  localparam int LPC_FRAME_W = 81;
  localparam int DEF_PKT_LEN = 16;

  // Keeps counters and pointers at least one bit wide when the size is 1.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with a registered head entry, registered not-full ready and level.
module axis_sync_fifo
  import axis_pkt_pkg::*;
#(
  parameter int WIDTH = LPC_FRAME_W + 1,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_push,
  input  logic [WIDTH-1:0]              i_din,
  input  logic                          i_pop,
  output logic [WIDTH-1:0]              o_head,
  output logic                          o_ready,
  output logic                          o_empty,
  output logic [clog2_min1(DEPTH):0]    o_level
);

  localparam int AW = clog2_min1(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_head;
  logic             r_ready;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [AW:0]      w_level;
  logic [AW:0]      w_wr_nxt;
  logic [AW:0]      w_rd_nxt;
  logic             w_full_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_empty    = (r_wr == r_rd);
  assign w_level    = r_wr - r_rd;
  assign w_push     = i_push & r_ready;
  assign w_pop      = i_pop & ~w_empty;
  assign w_wr_nxt   = w_push ? r_wr + ONE : r_wr;
  assign w_rd_nxt   = w_pop ? r_rd + ONE : r_rd;
  assign w_full_nxt = (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                      (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);

  // Head follows the entry behind it on a pop; the incoming frame becomes
  // head directly when it lands in an empty (or just-emptied) FIFO.
  always_comb begin
    w_head_nxt = r_head;
    if (w_pop) begin
      if (w_level > ONE)
        w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
      else if (w_push)
        w_head_nxt = i_din;
    end else if (w_empty && w_push) begin
      w_head_nxt = i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_head  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_head  <= w_head_nxt;
      r_ready <= ~w_full_nxt;
    end
  end

  assign o_head  = r_head;
  assign o_ready = r_ready;
  assign o_empty = w_empty;
  assign o_level = w_level;

endmodule

// File: rtl/axis_frame_packetizer.sv
// AXI4-Stream master for LPC encoder frames: buffers frames and generates TLAST
// every PKT_LEN beats or early on a producer end-of-stream flag.
module axis_frame_packetizer
  import axis_pkt_pkg::*;
#(
  parameter int DATA_W     = LPC_FRAME_W,
  parameter int FIFO_DEPTH = 4,
  parameter int PKT_LEN    = DEF_PKT_LEN,
  parameter int CNT_W      = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESET_N,
  input  logic [DATA_W-1:0]             SAMPLE,
  input  logic                          VALID_SAMPLE,
  input  logic                          SAMPLE_LAST,
  output logic                          READY,
  output logic                          TVALID,
  input  logic                          TREADY,
  output logic [DATA_W-1:0]             TDATA,
  output logic                          TLAST,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic [CNT_W-1:0]              PKT_COUNT
);

  localparam int BW = clog2_min1(PKT_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  logic [DATA_W:0] w_head;
  logic            w_empty;
  logic            w_last;
  logic            w_pop;
  logic [BW-1:0]   r_beat;
  logic [CNT_W-1:0] r_pkt_count;

  axis_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ACLK),
    .rst_n   (ARESET_N),
    .i_push  (VALID_SAMPLE),
    .i_din   ({SAMPLE_LAST, SAMPLE}),
    .i_pop   (TREADY),
    .o_head  (w_head),
    .o_ready (READY),
    .o_empty (w_empty),
    .o_level (FIFO_LEVEL)
  );

  assign TVALID = ~w_empty;
  assign TDATA  = w_head[DATA_W-1:0];
  assign w_last = (r_beat == LAST_BEAT) | w_head[DATA_W];
  assign TLAST  = TVALID & w_last;
  assign w_pop  = TVALID & TREADY;

  // An early end-of-stream closes the packet exactly like a full-length one.
  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      r_beat      <= '0;
      r_pkt_count <= '0;
    end else if (w_pop) begin
      if (w_last) begin
        r_beat      <= '0;
        r_pkt_count <= r_pkt_count + CNT_W'(1);
      end else begin
        r_beat      <= r_beat + BW'(1);
      end
    end
  end

  assign PKT_COUNT = r_pkt_count;

endmodule

// File: tb/tb_axis_frame_packetizer.sv
// Bench for axis_frame_packetizer: queue-based packet model plus directed scenarios.
module tb_axis_frame_packetizer;

  localparam int DW    = 81;
  localparam int DEPTH = 4;
  localparam int PL    = 16;
  localparam int CW    = 16;

  logic          ACLK = 1'b0;
  logic          ARESET_N = 1'b0;
  logic [DW-1:0] SAMPLE = '0;
  logic          VALID_SAMPLE = 1'b0;
  logic          SAMPLE_LAST = 1'b0;
  logic          READY;
  logic          TVALID;
  logic          TREADY = 1'b0;
  logic [DW-1:0] TDATA;
  logic          TLAST;
  logic [2:0]    FIFO_LEVEL;
  logic [CW-1:0] PKT_COUNT;

  logic [DW-1:0] b_sample = '0;
  logic          b_valid = 1'b0;
  logic          b_last_in = 1'b0;
  logic          b_ready;
  logic          b_tvalid;
  logic          b_tready = 1'b0;
  logic [DW-1:0] b_tdata;
  logic          b_tlast;
  logic [2:0]    b_level;
  logic [CW-1:0] b_pkt;

  axis_frame_packetizer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .PKT_LEN(PL), .CNT_W(CW)) dut (
    .ACLK(ACLK), .ARESET_N(ARESET_N), .SAMPLE(SAMPLE), .VALID_SAMPLE(VALID_SAMPLE),
    .SAMPLE_LAST(SAMPLE_LAST), .READY(READY), .TVALID(TVALID), .TREADY(TREADY),
    .TDATA(TDATA), .TLAST(TLAST), .FIFO_LEVEL(FIFO_LEVEL), .PKT_COUNT(PKT_COUNT));

  axis_frame_packetizer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .PKT_LEN(1), .CNT_W(CW)) dut1 (
    .ACLK(ACLK), .ARESET_N(ARESET_N), .SAMPLE(b_sample), .VALID_SAMPLE(b_valid),
    .SAMPLE_LAST(b_last_in), .READY(b_ready), .TVALID(b_tvalid), .TREADY(b_tready),
    .TDATA(b_tdata), .TLAST(b_tlast), .FIFO_LEVEL(b_level), .PKT_COUNT(b_pkt));

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: the FIFO is a queue of {last, data}; a packet closes on its PL-th beat or a flagged frame.
  logic [DW:0] mq[$];
  int          m_beat = 0;
  int unsigned m_pkt = 0;
  bit          m_armed = 1'b0;

  always @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      mq.delete();
      m_beat  = 0;
      m_pkt   = 0;
      m_armed = 1'b0;
    end else begin
      bit pu;
      bit po;
      pu = VALID_SAMPLE && m_armed && (mq.size() < DEPTH);
      po = (mq.size() > 0) && TREADY;
      if (po) begin
        if (m_beat == PL - 1 || mq[0][DW]) begin
          m_beat = 0;
          m_pkt++;
        end else begin
          m_beat++;
        end
        void'(mq.pop_front());
      end
      if (pu) mq.push_back({SAMPLE_LAST, SAMPLE});
      m_armed = 1'b1;
    end
  end

  always @(negedge ACLK) begin
    bit          ev;
    bit          el;
    logic [DW:0] hd;
    ev = ARESET_N && (mq.size() > 0);
    hd = '0;
    if (ev) hd = mq[0];
    el = ev && ((m_beat == PL - 1) || hd[DW]);
    chk("tvalid", TVALID, ev);
    chk("ready", READY, ARESET_N && m_armed && (mq.size() < DEPTH));
    chk("level", FIFO_LEVEL, mq.size());
    chk("pkt_count", PKT_COUNT, m_pkt % 65536);
    chk("tlast", TLAST, el);
    if (ev) chk("tdata", TDATA, hd[DW-1:0]);
    else if (!ARESET_N) chk("tdata_rst", TDATA, 0);
  end

  // Observed handshakes, cumulative; tl_pos holds 1-based beat numbers of TLAST beats.
  logic [DW-1:0] obs_data[$];
  int            tl_pos[$];
  logic [DW-1:0] b_obs[$];
  int            b_tl_cnt = 0;

  always @(negedge ACLK) begin
    if (ARESET_N && TVALID && TREADY) begin
      obs_data.push_back(TDATA);
      if (TLAST) tl_pos.push_back(obs_data.size());
    end
    if (ARESET_N && b_tvalid && b_tready) begin
      b_obs.push_back(b_tdata);
      if (b_tlast) b_tl_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic do_reset();
    ARESET_N = 1'b0;
    idle(2);
    ARESET_N = 1'b1;
    idle(1);
  endtask

  task automatic push_frame(input logic [DW-1:0] d, input bit last);
    int budget;
    bit acc;
    budget = 0;
    acc = 1'b0;
    SAMPLE = d;
    SAMPLE_LAST = last;
    VALID_SAMPLE = 1'b1;
    while (!acc && budget < 200) begin
      @(negedge ACLK);
      acc = READY;
      @(posedge ACLK);
      #1;
      budget++;
    end
    VALID_SAMPLE = 1'b0;
    SAMPLE_LAST = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic push_b(input logic [DW-1:0] d);
    int budget;
    bit acc;
    budget = 0;
    acc = 1'b0;
    b_sample = d;
    b_valid = 1'b1;
    while (!acc && budget < 200) begin
      @(negedge ACLK);
      acc = b_ready;
      @(posedge ACLK);
      #1;
      budget++;
    end
    b_valid = 1'b0;
    if (!acc) chk("push_b_timeout", 0, 1);
  endtask

  task automatic wait_empty();
    int b;
    b = 0;
    while (mq.size() > 0 && b < 1000) begin
      @(posedge ACLK);
      #1;
      b++;
    end
    if (mq.size() > 0) chk("drain_timeout", 0, 1);
    idle(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int  base;
    int  tbase;
    bit  done;

    // Reset state
    #3;
    chk("rst_tvalid", TVALID, 0);
    chk("rst_ready", READY, 0);
    chk("rst_level", FIFO_LEVEL, 0);
    chk("rst_pkt", PKT_COUNT, 0);
    @(posedge ACLK);
    #1;
    do_reset();

    // Full packet of 16 frames with TREADY held high
    TREADY = 1'b1;
    base = obs_data.size();
    tbase = tl_pos.size();
    push_frame(DW'(1), 1'b0);
    @(negedge ACLK);
    chk("first_tvalid", TVALID, 1);
    chk("first_tdata", TDATA, 1);
    @(posedge ACLK);
    #1;
    for (int i = 2; i <= 16; i++) push_frame(DW'(i), 1'b0);
    wait_empty();
    chk("t1_beats", obs_data.size() - base, 16);
    for (int i = 0; i < 16; i++) chk("t1_order", obs_data[base+i], i + 1);
    chk("t1_tlast_cnt", tl_pos.size() - tbase, 1);
    chk("t1_tlast_pos", tl_pos[tbase] - base, 16);
    chk("t1_pkt", PKT_COUNT, 1);

    // Back-pressure: 6 frames offered while the sink stalls for 10 cycles
    do_reset();
    TREADY = 1'b0;
    base = obs_data.size();
    fork
      begin
        for (int i = 0; i < 6; i++) push_frame(DW'(32 + i), 1'b0);
      end
      begin
        idle(8);
        @(negedge ACLK);
        chk("t2_level_full", FIFO_LEVEL, 4);
        chk("t2_ready_low", READY, 0);
        chk("t2_hold_data", TDATA, 32);
        chk("t2_hold_valid", TVALID, 1);
        @(posedge ACLK);
        #1;
        idle(1);
        TREADY = 1'b1;
      end
    join
    wait_empty();
    chk("t2_beats", obs_data.size() - base, 6);
    for (int i = 0; i < 6; i++) chk("t2_order", obs_data[base+i], 32 + i);

    // Early end-of-stream on frame 5, then a full packet
    do_reset();
    TREADY = 1'b1;
    base = obs_data.size();
    tbase = tl_pos.size();
    for (int i = 1; i <= 5; i++) push_frame(DW'(48 + i), i == 5);
    wait_empty();
    chk("t3_pkt_early", PKT_COUNT, 1);
    for (int i = 1; i <= 16; i++) push_frame(DW'(64 + i), 1'b0);
    wait_empty();
    chk("t3_tlast_cnt", tl_pos.size() - tbase, 2);
    chk("t3_tlast_early", tl_pos[tbase] - base, 5);
    chk("t3_tlast_next", tl_pos[tbase+1] - base, 21);
    chk("t3_pkt", PKT_COUNT, 2);

    // Random valid/ready, 1000 incrementing frames
    do_reset();
    base = obs_data.size();
    tbase = tl_pos.size();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(1) == 0) idle(1);
          push_frame(DW'(1000 + i), 1'b0);
        end
        wait_empty();
        done = 1'b1;
      end
      begin
        while (!done) begin
          TREADY = ($urandom_range(1) == 1);
          @(posedge ACLK);
          #1;
        end
      end
    join
    TREADY = 1'b1;
    chk("t4_beats", obs_data.size() - base, 1000);
    for (int i = 0; i < 1000; i++) chk("t4_order", obs_data[base+i], 1000 + i);
    chk("t4_tlast_cnt", tl_pos.size() - tbase, 62);
    for (int k = 0; k < 62; k++) chk("t4_tlast_pos", tl_pos[tbase+k] - base, 16 * (k + 1));
    chk("t4_pkt", PKT_COUNT, 62);

    // Asynchronous reset mid-packet with 3 frames buffered
    do_reset();
    TREADY = 1'b1;
    push_frame(DW'(96), 1'b0);
    push_frame(DW'(97), 1'b0);
    wait_empty();
    TREADY = 1'b0;
    for (int i = 0; i < 3; i++) push_frame(DW'(98 + i), 1'b0);
    @(negedge ACLK);
    chk("t5_level_pre", FIFO_LEVEL, 3);
    #2;
    ARESET_N = 1'b0;
    #1;
    chk("t5_async_tvalid", TVALID, 0);
    chk("t5_async_level", FIFO_LEVEL, 0);
    chk("t5_async_tlast", TLAST, 0);
    chk("t5_async_ready", READY, 0);
    @(posedge ACLK);
    #1;
    ARESET_N = 1'b1;
    idle(1);
    TREADY = 1'b1;
    base = obs_data.size();
    tbase = tl_pos.size();
    push_frame(DW'(170), 1'b0);
    @(negedge ACLK);
    chk("t5_new_tdata", TDATA, 170);
    chk("t5_new_tlast", TLAST, 0);
    @(posedge ACLK);
    #1;
    for (int i = 1; i < 16; i++) push_frame(DW'(170 + i), 1'b0);
    wait_empty();
    chk("t5_first_after", obs_data[base], 170);
    chk("t5_beats", obs_data.size() - base, 16);
    chk("t5_tlast_cnt", tl_pos.size() - tbase, 1);
    chk("t5_tlast_pos", tl_pos[tbase] - base, 16);

    // PKT_LEN=1 instance: every beat closes a packet
    do_reset();
    b_tready = 1'b1;
    for (int i = 0; i < 5; i++) push_b(DW'(113 + i));
    idle(4);
    chk("t6_beats", b_obs.size(), 5);
    chk("t6_tlast_cnt", b_tl_cnt, 5);
    chk("t6_pkt", b_pkt, 5);
    for (int i = 0; i < 5; i++) chk("t6_order", b_obs[i], 113 + i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
